// File: rtl/obs_pkg.sv
// rtl/obs_pkg.sv - shared constants, types and operand selection for the OBS split scheduler
//
// Purpose:
//   Common definitions for the 26-bit OBS multiplier front end.
//   N : operand width (even)
//   H : half-operand width, N/2
//   P : sub-product width, 2*H-1
//   state_t : scheduler states IDLE, ISSUE, WAIT, DONE
//   slot_t  : index of the sub-product currently scheduled
//
// Configuration macro:
//   OBS_KARATSUBA_EN - when defined, three sub-products are issued
//                      (Ae*Be, Ao*Bo, (Ae^Ao)*(Be^Bo)) instead of four.

package obs_pkg;

  localparam int N = 26;
  localparam int H = N / 2;
  localparam int P = 2 * H - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [1:0] slot_t;

`ifdef OBS_KARATSUBA_EN
  localparam slot_t LAST_K = 2'd2;
`else
  localparam slot_t LAST_K = 2'd3;
`endif

  // Sub-operand pair for schedule step k, packed as {a, b}.
  function automatic logic [2*H-1:0] sel_operands(
    input slot_t        k,
    input logic [H-1:0] ae,
    input logic [H-1:0] ao,
    input logic [H-1:0] be,
    input logic [H-1:0] bo
  );
    logic [2*H-1:0] r;
    r = '0;
`ifdef OBS_KARATSUBA_EN
    case (k)
      2'd0:    r = {ae, be};
      2'd1:    r = {ao, bo};
      2'd2:    r = {ae ^ ao, be ^ bo};
      default: r = '0;
    endcase
`else
    case (k)
      2'd0:    r = {ae, be};
      2'd1:    r = {ae, bo};
      2'd2:    r = {ao, be};
      default: r = {ao, bo};
    endcase
`endif
    return r;
  endfunction

endpackage

// File: rtl/obs_deinterleave.sv
// rtl/obs_deinterleave.sv - even/odd coefficient split of one GF(2) polynomial operand
//
// Purpose:
//   Purely combinational. Coefficient 2i of the operand goes to even[i],
//   coefficient 2i+1 goes to odd[i]. Instantiated once per operand.
//
// Ports:
//   op   in  [W-1:0]   operand, bit i is the coefficient of x^i
//   even out [W/2-1:0] even-indexed coefficients
//   odd  out [W/2-1:0] odd-indexed coefficients

module obs_deinterleave
  import obs_pkg::*;
#(
  parameter int W = N
) (
  input  logic [W-1:0]   op,
  output logic [W/2-1:0] even,
  output logic [W/2-1:0] odd
);

  for (genvar i = 0; i < W / 2; i++) begin : g_split
    assign even[i] = op[2*i];
    assign odd[i]  = op[2*i+1];
  end

endmodule

// File: rtl/obs_split_scheduler_26bit.sv
// rtl/obs_split_scheduler_26bit.sv - operand split and serial sub-product scheduler for the 26-bit OBS level
//
// Purpose:
//   Accepts two 26-bit GF(2) operands, splits each into 13-bit even/odd
//   halves and runs the sub-products one at a time through a shared 13x13
//   sub-multiplier. The captured 25-bit partial products are presented as
//   the bundle out_in1..out_in4 for the overlap stage.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand pair handshake, in_a/in_b operands
//   sm_req_valid/ready sub-multiply request, sm_a/sm_b sub-operands
//   sm_rsp_valid       one-cycle sub-product pulse, sm_rsp sub-product
//   out_valid/ready    bundle handshake, out_in1..out_in4 partial products
//
// Configuration macro:
//   OBS_KARATSUBA_EN - three-product schedule; out_in2 carries the whole
//                      middle term and out_in3 is forced to zero.

module obs_split_scheduler_26bit
  import obs_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,

  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,

  output logic         sm_req_valid,
  input  logic         sm_req_ready,
  output logic [H-1:0] sm_a,
  output logic [H-1:0] sm_b,
  input  logic         sm_rsp_valid,
  input  logic [P-1:0] sm_rsp,

  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_in1,
  output logic [P-1:0] out_in2,
  output logic [P-1:0] out_in3,
  output logic [P-1:0] out_in4
);

  state_t       state;
  slot_t        k;
  slot_t        k_next;

  logic [H-1:0] ae, ao, be, bo;
  logic [H-1:0] a_even, a_odd, b_even, b_odd;

  obs_deinterleave #(.W(N)) u_split_a (
    .op   (in_a),
    .even (a_even),
    .odd  (a_odd)
  );

  obs_deinterleave #(.W(N)) u_split_b (
    .op   (in_b),
    .even (b_even),
    .odd  (b_odd)
  );

  assign in_ready = (state == IDLE);
  assign k_next   = k + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      ae           <= '0;
      ao           <= '0;
      be           <= '0;
      bo           <= '0;
      sm_req_valid <= 1'b0;
      sm_a         <= '0;
      sm_b         <= '0;
      out_valid    <= 1'b0;
      out_in1      <= '0;
      out_in2      <= '0;
      out_in3      <= '0;
      out_in4      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ae           <= a_even;
            ao           <= a_odd;
            be           <= b_even;
            bo           <= b_odd;
            k            <= '0;
            // The first request uses the fresh halves since the latches
            // only take effect after this edge.
            {sm_a, sm_b} <= sel_operands(2'd0, a_even, a_odd, b_even, b_odd);
            sm_req_valid <= 1'b1;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          if (sm_req_ready) begin
            sm_req_valid <= 1'b0;
            state        <= WAIT;
          end
        end

        WAIT: begin
          if (sm_rsp_valid) begin
`ifdef OBS_KARATSUBA_EN
            case (k)
              2'd0: out_in1 <= sm_rsp;
              2'd1: out_in4 <= sm_rsp;
              default: begin
                // Middle term recovered as M ^ Ae*Be ^ Ao*Bo; slot 3 unused.
                out_in2 <= sm_rsp ^ out_in1 ^ out_in4;
                out_in3 <= '0;
              end
            endcase
`else
            case (k)
              2'd0:    out_in1 <= sm_rsp;
              2'd1:    out_in2 <= sm_rsp;
              2'd2:    out_in3 <= sm_rsp;
              default: out_in4 <= sm_rsp;
            endcase
`endif
            if (k == LAST_K) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              k            <= k_next;
              {sm_a, sm_b} <= sel_operands(k_next, ae, ao, be, bo);
              sm_req_valid <= 1'b1;
              state        <= ISSUE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obs_split_scheduler_26bit.sv
// tb/tb_obs_split_scheduler_26bit.sv - scoreboard bench for obs_split_scheduler_26bit

module tb_obs_split_scheduler_26bit;

  localparam int N = 26;
  localparam int H = 13;
  localparam int P = 25;
`ifdef OBS_KARATSUBA_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 9;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic         sm_req_valid;
  logic         sm_req_ready = 1'b0;
  logic [H-1:0] sm_a, sm_b;
  logic         sm_rsp_valid = 1'b0;
  logic [P-1:0] sm_rsp = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [P-1:0] out_in1, out_in2, out_in3, out_in4;

  always #5 clk = ~clk;

  obs_split_scheduler_26bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .sm_req_valid (sm_req_valid),
    .sm_req_ready (sm_req_ready),
    .sm_a         (sm_a),
    .sm_b         (sm_b),
    .sm_rsp_valid (sm_rsp_valid),
    .sm_rsp       (sm_rsp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_in1      (out_in1),
    .out_in2      (out_in2),
    .out_in3      (out_in3),
    .out_in4      (out_in4)
  );

  typedef struct {
    logic [P-1:0]     i1, i2, i3, i4;
    logic [2*N-2:0]   prod;
  } exp_t;

  exp_t           exp_q[$];
  logic [2*H-1:0] req_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int hs_count = 0;
  int late_hs = -1;
  bit sm_busy = 1'b0;
  bit rnd_mode = 1'b0;
  int req_stall_cfg = 0;
  int rsp_delay_cfg = 0;
  int out_stall_cfg = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference carry-less products
  function automatic logic [P-1:0] clmul_h(input logic [H-1:0] a, input logic [H-1:0] b);
    logic [P-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++)
      if (b[i]) r ^= {{(H-1){1'b0}}, a} << i;
    return r;
  endfunction

  function automatic logic [2*N-2:0] clmul_n(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-2:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (b[i]) r ^= {{(N-1){1'b0}}, a} << i;
    return r;
  endfunction

  // Overlap stage: A(x)B(x) = in1(x^2) + x*(in2+in3)(x^2) + x^2*in4(x^2)
  function automatic logic [2*N-2:0] overlap(input logic [P-1:0] i1, input logic [P-1:0] i2,
                                             input logic [P-1:0] i3, input logic [P-1:0] i4);
    logic [2*N-2:0] r;
    r = '0;
    for (int i = 0; i < P; i++) begin
      r[2*i]   ^= i1[i];
      r[2*i+1] ^= i2[i] ^ i3[i];
      r[2*i+2] ^= i4[i];
    end
    return r;
  endfunction

  task automatic push_expect(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [H-1:0] ae, ao, be, bo;
    exp_t e;
    for (int i = 0; i < H; i++) begin
      ae[i] = a[2*i]; ao[i] = a[2*i+1];
      be[i] = b[2*i]; bo[i] = b[2*i+1];
    end
    e.prod = clmul_n(a, b);
    e.i1   = clmul_h(ae, be);
    e.i4   = clmul_h(ao, bo);
`ifdef OBS_KARATSUBA_EN
    e.i2 = clmul_h(ae, bo) ^ clmul_h(ao, be);
    e.i3 = '0;
    req_q.push_back({ae, be});
    req_q.push_back({ao, bo});
    req_q.push_back({ae ^ ao, be ^ bo});
`else
    e.i2 = clmul_h(ae, bo);
    e.i3 = clmul_h(ao, be);
    req_q.push_back({ae, be});
    req_q.push_back({ae, bo});
    req_q.push_back({ao, be});
    req_q.push_back({ao, bo});
`endif
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      return;
    end
    in_valid   = 1'b1;
    in_a       = a;
    in_b       = b;
    accept_cyc = cyc;
    push_expect(a, b);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = N'($urandom);
    in_b     = N'($urandom);
  endtask

  task automatic wait_out_latency();
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_seen", out_valid, 1);
    check("latency", cyc - accept_cyc, LAT);
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("drain_bundles", exp_q.size(), 0);
    check("drain_requests", req_q.size(), 0);
  endtask

  // Behavioural sub-multiplier
  initial begin : submul
    logic [H-1:0] sa, sb;
    bit hs_pend;
    int cnt, rwait;
    logic [2*H-1:0] er;
    hs_pend = 1'b0; cnt = 0; rwait = -1; sa = '0; sb = '0;
    forever begin
      @(negedge clk);
      sm_rsp_valid = 1'b0;
      sm_req_ready = 1'b0;
      if (!rst_n) rwait = -1;
      if (hs_pend) begin
        hs_pend = 1'b0;
        sm_busy = 1'b1;
        hs_count++;
        if (hs_count == late_hs) cnt = 8;
        else cnt = rnd_mode ? int'($urandom_range(0, 3)) : rsp_delay_cfg;
      end
      if (sm_busy) begin
        check("one_outstanding", sm_req_valid, 0);
        if (cnt == 0) begin
          sm_rsp_valid = 1'b1;
          sm_rsp       = clmul_h(sa, sb);
          sm_busy      = 1'b0;
        end else begin
          cnt--;
          sm_rsp = P'($urandom);
        end
      end else begin
        if (rnd_mode && $urandom_range(0, 7) == 0) begin
          sm_rsp_valid = 1'b1;
          sm_rsp       = P'($urandom);
        end
        if (sm_req_valid) begin
          if (rwait < 0) begin
            rwait = rnd_mode ? int'($urandom_range(0, 3)) : req_stall_cfg;
            sa = sm_a;
            sb = sm_b;
            if (req_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL req_unexpected: got a=%0h b=%0h with none expected", sm_a, sm_b);
            end else begin
              er = req_q.pop_front();
              check("req_operands", {sm_a, sm_b}, er);
            end
          end else begin
            check("req_a_stable", sm_a, sa);
            check("req_b_stable", sm_b, sb);
          end
          if (rwait == 0) begin
            sm_req_ready = 1'b1;
            hs_pend      = 1'b1;
            rwait        = -1;
          end else begin
            rwait--;
          end
        end
      end
    end
  end

  // Output monitor / scoreboard
  initial begin : outmon
    logic [P-1:0] s1, s2, s3, s4;
    bit stalled;
    int ocnt;
    exp_t e;
    stalled = 1'b0; ocnt = 0; s1 = '0; s2 = '0; s3 = '0; s4 = '0;
    forever begin
      @(negedge clk);
      out_ready = 1'b0;
      if (out_valid) begin
        if (!stalled) begin
          stalled = 1'b1;
          ocnt = rnd_mode ? int'($urandom_range(0, 2)) : out_stall_cfg;
          s1 = out_in1; s2 = out_in2; s3 = out_in3; s4 = out_in4;
        end else begin
          check("hold_in1", out_in1, s1);
          check("hold_in2", out_in2, s2);
          check("hold_in3", out_in3, s3);
          check("hold_in4", out_in4, s4);
        end
        if (ocnt == 0) begin
          out_ready = 1'b1;
          stalled   = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bundle_unexpected: got in1=%0h with none expected", out_in1);
          end else begin
            e = exp_q.pop_front();
            check("in1", out_in1, e.i1);
            check("in2", out_in2, e.i2);
            check("in3", out_in3, e.i3);
            check("in4", out_in4, e.i4);
            check("overlap", overlap(out_in1, out_in2, out_in3, out_in4), e.prod);
          end
        end else begin
          ocnt--;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : main
    int acc1, t;
    logic [N-1:0] a, b;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_req_valid", sm_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sm_a", sm_a, 0);
    check("rst_sm_b", sm_b, 0);
    check("rst_in1", out_in1, 0);
    check("rst_in2", out_in2, 0);
    check("rst_in3", out_in3, 0);
    check("rst_in4", out_in4, 0);

    send(26'd1, 26'd1); wait_out_latency(); drain(100);
    send(26'd2, 26'd2); wait_out_latency(); drain(100);
    send(26'd3, 26'd3); wait_out_latency(); drain(100);

    // back-to-back throughput
    send(26'h2AB_CDEF, 26'h155_4321);
    acc1 = accept_cyc;
    send(26'h3FF_0001, 26'h000_FFFF);
    check("throughput", accept_cyc - acc1, LAT + 1);
    drain(100);

    // backpressure on every handshake
    req_stall_cfg = 5; rsp_delay_cfg = 3; out_stall_cfg = 4;
    send(26'h123_4567, 26'h2DE_AD01);
    drain(400);
    req_stall_cfg = 0; rsp_delay_cfg = 0; out_stall_cfg = 0;

    // reset while waiting on the third product, with its response still in flight
    hs_count = 0;
    late_hs  = 3;
    send(26'h3A5_5A5A, 26'h0F0_F0F3);
    t = 0;
    while (hs_count < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reach_wait_k2", hs_count, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    req_q.delete();
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_req_valid", sm_req_valid, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_sm_a", sm_a, 0);
    check("abort_sm_b", sm_b, 0);
    repeat (12) begin
      @(negedge clk);
      check("late_rsp_idle", in_ready, 1);
      check("late_rsp_noreq", sm_req_valid, 0);
    end
    check("late_rsp_busy_done", sm_busy, 0);
    check("late_in1", out_in1, 0);
    check("late_in2", out_in2, 0);
    check("late_in3", out_in3, 0);
    check("late_in4", out_in4, 0);
    late_hs = -1;

    // randomized traffic with random stalls and spurious response pulses
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      if (i == 0) begin a = '0; b = N'($urandom); end
      if (i == 1) begin a = '1; b = '1; end
      if (i == 2) begin a = N'($urandom); b = '0; end
      if (i == 3) begin a = '1; b = N'($urandom); end
      send(a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
